// File: rtl/bcd_counter_pkg.sv
// Shared types and helpers for the multi-digit radix-N up-counter.
// Optional terminal-count output is enabled with the BCD_COUNTER_TC_EN macro.
package bcd_counter_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  // A 4-bit digit can only hold radix 2..10 without producing non-decimal codes.
  function automatic bit radix_ok(input int base);
    return (base >= 2) && (base <= 10);
  endfunction

  function automatic bit digits_ok(input int digits);
    return digits >= 1;
  endfunction

  function automatic digit_t max_digit(input int base);
    return digit_t'(base - 1);
  endfunction

endpackage

// File: rtl/bcd_counter_if.sv
// Output bundle of bcd_counter: packed digits plus, with BCD_COUNTER_TC_EN,
// the combinational terminal-count flag.
interface bcd_counter_if #(
  parameter int DIGITS = 4
);
  import bcd_counter_pkg::*;

  logic [DIGIT_W*DIGITS-1:0] data;

`ifdef BCD_COUNTER_TC_EN
  logic tc;

  modport master (output data, output tc);
  modport slave  (input  data, input  tc);
`else
  modport master (output data);
  modport slave  (input  data);
`endif

endinterface

// File: rtl/bcd_counter_digit.sv
// One radix-BASE digit register; increments when inc_in is high and wraps
// at BASE-1, raising carry_out in the same cycle.
module bcd_digit
  import bcd_counter_pkg::*;
#(
  parameter int BASE = 10
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   inc_in,
  output digit_t value,
  output logic   carry_out
);

  localparam digit_t MAX = max_digit(BASE);

  logic at_max;

  assign at_max    = (value == MAX);
  assign carry_out = inc_in && at_max;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (inc_in) begin
      value <= at_max ? '0 : value + digit_t'(1);
    end
  end

endmodule

// File: rtl/bcd_counter.sv
// Free-running multi-digit up-counter with per-digit radix PARAM_BASE.
// Define BCD_COUNTER_TC_EN to add the terminal-count output tc to the bus.
module bcd_counter
  import bcd_counter_pkg::*;
#(
  parameter int PARAM_DIGITS = 4,
  parameter int PARAM_BASE   = 10
) (
  input  logic          clk,
  input  logic          rst,
  bcd_counter_if.master bus
);

  if (!radix_ok(PARAM_BASE)) begin : g_bad_base
    $error("bcd_counter: PARAM_BASE=%0d outside legal range 2..10", PARAM_BASE);
  end

  if (!digits_ok(PARAM_DIGITS)) begin : g_bad_digits
    $error("bcd_counter: PARAM_DIGITS=%0d must be at least 1", PARAM_DIGITS);
  end

  // carry[i] is the increment enable of digit i; carry[PARAM_DIGITS] means all digits at max.
  logic [PARAM_DIGITS:0]              carry;
  logic [DIGIT_W*PARAM_DIGITS-1:0]    data;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < PARAM_DIGITS; i++) begin : g_digit
    digit_t value;

    bcd_digit #(
      .BASE (PARAM_BASE)
    ) u_digit (
      .clk       (clk),
      .rst       (rst),
      .inc_in    (carry[i]),
      .value     (value),
      .carry_out (carry[i+1])
    );

    assign data[DIGIT_W*i +: DIGIT_W] = value;
  end

  assign bus.data = data;

`ifdef BCD_COUNTER_TC_EN
  assign bus.tc = rst && carry[PARAM_DIGITS];
`else
  logic wrap_unused;
  assign wrap_unused = carry[PARAM_DIGITS];
`endif

endmodule

// File: tb/tb_bcd_counter.sv
// Directed bench: a 4-digit decimal counter and a 2-digit octal counter
// run side by side from a shared clock and reset.
module tb_bcd_counter;

  logic clk;
  logic rst;

  bcd_counter_if #(.DIGITS(4)) bus10 ();
  bcd_counter_if #(.DIGITS(2)) bus8  ();

  bcd_counter #(.PARAM_DIGITS(4), .PARAM_BASE(10)) dut10 (
    .clk (clk),
    .rst (rst),
    .bus (bus10)
  );

  bcd_counter #(.PARAM_DIGITS(2), .PARAM_BASE(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          edges;
    logic [15:0] exp10;
    logic [7:0]  exp8;
    logic        tc10;
    logic        tc8;
  } vec_t;

  vec_t vecs [16];
  int   checks   = 0;
  int   failures = 0;
  int   edges    = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t edges=%0d)", name, act, exp, $time, edges);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e10, input logic [7:0] e8,
                         input logic t10, input logic t8);
    chk({tag, " data10"}, bus10.data, e10);
    chk({tag, " data8"}, {8'h00, bus8.data}, {8'h00, e8});
`ifdef BCD_COUNTER_TC_EN
    chk({tag, " tc10"}, {15'h0, bus10.tc}, {15'h0, t10});
    chk({tag, " tc8"}, {15'h0, bus8.tc}, {15'h0, t8});
`else
    if (t10 === 1'bx || t8 === 1'bx) $display("note: unknown tc expectation in %s", tag);
`endif
  endtask

  // Advance to the given number of edges since reset release, sampling 1 ns after the edge.
  task automatic run_to(input int target);
    while (edges < target) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst   = 1'b1;
    edges = 0;
  endtask

  initial begin
    vecs[0]  = '{1,     16'h0001, 8'h01, 1'b0, 1'b0};
    vecs[1]  = '{7,     16'h0007, 8'h07, 1'b0, 1'b0};
    vecs[2]  = '{8,     16'h0008, 8'h10, 1'b0, 1'b0};
    vecs[3]  = '{9,     16'h0009, 8'h11, 1'b0, 1'b0};
    vecs[4]  = '{10,    16'h0010, 8'h12, 1'b0, 1'b0};
    vecs[5]  = '{30,    16'h0030, 8'h36, 1'b0, 1'b0};
    vecs[6]  = '{63,    16'h0063, 8'h77, 1'b0, 1'b1};
    vecs[7]  = '{64,    16'h0064, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{99,    16'h0099, 8'h43, 1'b0, 1'b0};
    vecs[9]  = '{100,   16'h0100, 8'h44, 1'b0, 1'b0};
    vecs[10] = '{999,   16'h0999, 8'h47, 1'b0, 1'b0};
    vecs[11] = '{1000,  16'h1000, 8'h50, 1'b0, 1'b0};
    vecs[12] = '{9998,  16'h9998, 8'h16, 1'b0, 1'b0};
    vecs[13] = '{9999,  16'h9999, 8'h17, 1'b1, 1'b0};
    vecs[14] = '{10000, 16'h0000, 8'h20, 1'b0, 1'b0};
    vecs[15] = '{10001, 16'h0001, 8'h21, 1'b0, 1'b0};

    // Reset asserted before the first clock edge, held across one edge.
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 chk_all("reset_no_edge", 16'h0000, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1 chk_all("reset_held_edge", 16'h0000, 8'h00, 1'b0, 1'b0);

    release_reset();
    #1 chk_all("released_no_edge", 16'h0000, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      run_to(vecs[i].edges);
      chk_all($sformatf("vec%0d", i), vecs[i].exp10, vecs[i].exp8, vecs[i].tc10, vecs[i].tc8);
    end

    // Async reset 3 ns after an edge clears before the next edge.
    run_to(edges + 1);
    #2 rst = 1'b0;
    #1 chk_all("async_reset", 16'h0000, 8'h00, 1'b0, 1'b0);
    release_reset();
    run_to(1);
    chk_all("restart", 16'h0001, 8'h01, 1'b0, 1'b0);

    // Terminal count must drop immediately when reset hits at 9999.
    run_to(9999);
    chk_all("at_9999", 16'h9999, 8'h17, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1 chk_all("reset_at_9999", 16'h0000, 8'h00, 1'b0, 1'b0);
    release_reset();
    run_to(63);
    chk_all("restart_63", 16'h0063, 8'h77, 1'b0, 1'b1);
    run_to(64);
    chk_all("restart_64", 16'h0064, 8'h00, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
